// File: rtl/phase_acc_pipe_if.sv
// phase_acc_pipe_if: sample input and aligned result bundle for the phase accumulator
interface phase_acc_pipe_if #(
  parameter int DATA_W = 16
);
  logic in_valid;
  logic clr;
  logic add_sub;
  logic [DATA_W-1:0] D;
  logic out_valid;
  logic [DATA_W-1:0] Q;
  logic wrap;
  modport master (output in_valid, clr, add_sub, D, input out_valid, Q, wrap);
  modport slave (input in_valid, clr, add_sub, D, output out_valid, Q, wrap);
endinterface

// File: rtl/phase_acc_pipe.sv
// phase_acc_pipe: slice-pipelined add/sub phase accumulator with clear and aligned wrap output
module phase_acc_pipe #(
  parameter int DATA_W = 16,
  parameter int SLICE_W = 4
) (
  input logic clk,
  input logic rst,
  phase_acc_pipe_if.slave io
);
  localparam int NSLICE = (DATA_W + SLICE_W - 1) / SLICE_W;
  localparam int PW = NSLICE * SLICE_W;
  localparam int TW = DATA_W - (NSLICE - 1) * SLICE_W;
  localparam logic [PW:0] TOP = (PW + 1)'(1) << DATA_W;
  localparam logic [PW-1:0] MASK = PW'(TOP - (PW + 1)'(1));
  logic [NSLICE-1:0] v_q, clr_q, sub_q, c_q, co;
  logic [NSLICE-1:0][PW-1:0] d_q, r_q, r_d;
  logic [NSLICE-1:0][SLICE_W:0] res;
  logic [PW-1:0] acc_q, acc_d;
  logic out_valid_q, wrap_q;
  logic [DATA_W-1:0] q_q;
  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < NSLICE; k++) begin
      res[k] = sub_q[k]
        ? {1'b0, acc_q[k*SLICE_W +: SLICE_W] & {SLICE_W{~clr_q[k]}}} - {1'b0, d_q[k][k*SLICE_W +: SLICE_W]} - (SLICE_W + 1)'(c_q[k])
        : {1'b0, acc_q[k*SLICE_W +: SLICE_W] & {SLICE_W{~clr_q[k]}}} + {1'b0, d_q[k][k*SLICE_W +: SLICE_W]} + (SLICE_W + 1)'(c_q[k]);
      co[k] = res[k][(k == NSLICE - 1) ? TW : SLICE_W];
      r_d[k] = r_q[k];
      r_d[k][k*SLICE_W +: SLICE_W] = res[k][SLICE_W-1:0];
      acc_d[k*SLICE_W +: SLICE_W] = v_q[k] ? res[k][SLICE_W-1:0] : acc_q[k*SLICE_W +: SLICE_W];
    end
    acc_d = acc_d & MASK;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      clr_q <= '0;
      sub_q <= '0;
      c_q <= '0;
      d_q <= '0;
      r_q <= '0;
      acc_q <= '0;
      out_valid_q <= 1'b0;
      q_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      v_q[0] <= io.in_valid;
      clr_q[0] <= io.clr;
      sub_q[0] <= io.add_sub;
      c_q[0] <= 1'b0;
      d_q[0] <= PW'(io.D);
      r_q[0] <= '0;
      for (int k = 1; k < NSLICE; k++) begin
        v_q[k] <= v_q[k-1];
        clr_q[k] <= clr_q[k-1];
        sub_q[k] <= sub_q[k-1];
        c_q[k] <= co[k-1];
        d_q[k] <= d_q[k-1];
        r_q[k] <= r_d[k-1];
      end
      acc_q <= acc_d;
      out_valid_q <= v_q[NSLICE-1];
      q_q <= v_q[NSLICE-1] ? DATA_W'(r_d[NSLICE-1]) : q_q;
      wrap_q <= v_q[NSLICE-1] ? co[NSLICE-1] : wrap_q;
    end
  end
  assign io.out_valid = out_valid_q;
  assign io.Q = q_q;
  assign io.wrap = wrap_q;
endmodule

// File: tb/tb_phase_acc_pipe.sv
// tb_phase_acc_pipe: directed and model-checked streams against three accumulator configurations
module tb_phase_acc_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  phase_acc_pipe_if #(.DATA_W(16)) io16 ();
  phase_acc_pipe_if #(.DATA_W(18)) io18 ();
  phase_acc_pipe_if #(.DATA_W(8)) io8 ();
  phase_acc_pipe #(.DATA_W(16), .SLICE_W(4)) u16 (.clk(clk), .rst(rst), .io(io16));
  phase_acc_pipe #(.DATA_W(18), .SLICE_W(4)) u18 (.clk(clk), .rst(rst), .io(io18));
  phase_acc_pipe #(.DATA_W(8), .SLICE_W(8)) u8 (.clk(clk), .rst(rst), .io(io8));
  typedef struct {
    logic [31:0] q;
    logic w;
    int t;
  } exp_t;
  exp_t e16[$], e18[$], e8[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulses16 = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (io16.out_valid === 1'b1) begin
      pulses16++;
      if (e16.size() == 0) check("spurious16", 1, 0);
      else begin
        check("q16", 32'(io16.Q), e16[0].q);
        check("wrap16", 32'(io16.wrap), 32'(e16[0].w));
        check("lat16", cyc, e16[0].t);
        e16.delete(0);
      end
    end
    if (io18.out_valid === 1'b1) begin
      if (e18.size() == 0) check("spurious18", 1, 0);
      else begin
        check("q18", 32'(io18.Q), e18[0].q);
        check("wrap18", 32'(io18.wrap), 32'(e18[0].w));
        check("lat18", cyc, e18[0].t);
        e18.delete(0);
      end
    end
    if (io8.out_valid === 1'b1) begin
      if (e8.size() == 0) check("spurious8", 1, 0);
      else begin
        check("q8", 32'(io8.Q), e8[0].q);
        check("wrap8", 32'(io8.wrap), 32'(e8[0].w));
        check("lat8", cyc, e8[0].t);
        e8.delete(0);
      end
    end
  end
  task automatic s16(input logic c, input logic s, input logic [15:0] d, input logic [15:0] q, input logic w);
    exp_t e;
    io16.in_valid = 1'b1;
    io16.clr = c;
    io16.add_sub = s;
    io16.D = d;
    e.q = 32'(q);
    e.w = w;
    e.t = cyc + 5;
    e16.push_back(e);
    @(negedge clk);
    io16.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && (e16.size() + e18.size() + e8.size()) != 0; i++) @(negedge clk);
    check("drain16", e16.size(), 0);
    check("drain18", e18.size(), 0);
    check("drain8", e8.size(), 0);
  endtask
  task automatic model(input int wd, input logic c, input logic s, input logic [31:0] d,
                       inout logic [31:0] m, output logic [31:0] q, output logic w);
    longint b, r, md;
    md = longint'(1) << wd;
    b = c ? 64'sd0 : longint'(m);
    r = s ? b - longint'(d) : b + longint'(d);
    w = s ? (r < 0) : (r >= md);
    q = 32'(r & (md - 1));
    m = q;
  endtask
  initial begin
    int p0, gap, sel;
    logic c, s, w;
    logic [31:0] d, q, m16, m18, m8;
    exp_t e;
    io16.in_valid = 1'b0; io16.clr = 1'b0; io16.add_sub = 1'b0; io16.D = '0;
    io18.in_valid = 1'b0; io18.clr = 1'b0; io18.add_sub = 1'b0; io18.D = '0;
    io8.in_valid = 1'b0; io8.clr = 1'b0; io8.add_sub = 1'b0; io8.D = '0;
    m16 = 0; m18 = 0; m8 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_q16", 32'(io16.Q), 0);
    check("rst_wrap16", 32'(io16.wrap), 0);
    check("rst_ov16", 32'(io16.out_valid), 0);
    check("rst_q18", 32'(io18.Q), 0);
    check("rst_q8", 32'(io8.Q), 0);
    s16(0, 0, 16'h0001, 16'h0001, 0);
    s16(0, 0, 16'h0001, 16'h0002, 0);
    s16(0, 0, 16'h0001, 16'h0003, 0);
    s16(1, 0, 16'h0FFF, 16'h0FFF, 0);
    s16(0, 0, 16'h0001, 16'h1000, 0);
    s16(1, 0, 16'hFFFF, 16'hFFFF, 0);
    s16(0, 0, 16'h0002, 16'h0001, 1);
    s16(1, 0, 16'h0005, 16'h0005, 0);
    s16(0, 1, 16'h0007, 16'hFFFE, 1);
    s16(0, 1, 16'h0001, 16'hFFFD, 0);
    s16(1, 1, 16'h0003, 16'hFFFD, 1);
    s16(1, 0, 16'h0000, 16'h0000, 0);
    s16(1, 0, 16'h1234, 16'h1234, 0);
    s16(0, 1, 16'h0034, 16'h1200, 0);
    s16(0, 0, 16'h8000, 16'h9200, 0);
    drain();
    p0 = pulses16;
    s16(1, 0, 16'h1234, 16'h1234, 0);
    repeat (1) @(negedge clk);
    s16(0, 1, 16'h0034, 16'h1200, 0);
    repeat (3) @(negedge clk);
    s16(0, 0, 16'h8000, 16'h9200, 0);
    drain();
    check("gap_pulses", pulses16 - p0, 3);
    p0 = pulses16;
    io16.in_valid = 1'b1; io16.clr = 1'b1; io16.add_sub = 1'b0; io16.D = 16'h0011;
    @(negedge clk);
    io16.clr = 1'b0; io16.D = 16'h0022;
    @(negedge clk);
    io16.D = 16'h0033;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    io16.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_flight_pulses", pulses16 - p0, 0);
    check("rst_flight_q", 32'(io16.Q), 0);
    check("rst_flight_wrap", 32'(io16.wrap), 0);
    s16(0, 0, 16'h0003, 16'h0003, 0);
    drain();
    for (int i = 0; i < 300; i++) begin
      c = (i == 0) || ($urandom_range(7) == 0);
      s = 1'($urandom_range(1));
      d = $urandom;
      sel = $urandom_range(9);
      if (sel == 0) d = 32'h0;
      else if (sel == 1) d = 32'hFFFF_FFFF;
      io16.in_valid = 1'b1; io16.clr = c; io16.add_sub = s; io16.D = d[15:0];
      io18.in_valid = 1'b1; io18.clr = c; io18.add_sub = s; io18.D = d[17:0];
      io8.in_valid = 1'b1; io8.clr = c; io8.add_sub = s; io8.D = d[7:0];
      model(16, c, s, d & 32'hFFFF, m16, q, w);
      e.q = q; e.w = w; e.t = cyc + 5; e16.push_back(e);
      model(18, c, s, d & 32'h3FFFF, m18, q, w);
      e.q = q; e.w = w; e.t = cyc + 6; e18.push_back(e);
      model(8, c, s, d & 32'hFF, m8, q, w);
      e.q = q; e.w = w; e.t = cyc + 2; e8.push_back(e);
      @(negedge clk);
      io16.in_valid = 1'b0; io18.in_valid = 1'b0; io8.in_valid = 1'b0;
      gap = ($urandom_range(3) == 0) ? $urandom_range(3, 1) : 0;
      repeat (gap) @(negedge clk);
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
